// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset constants, fetch FSM states,
// and opcode helpers used by the neighbouring decode stages.
package mips_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_ST  = 6'b010101;
  localparam logic [3:0] OP_COND_J_PFX = 4'b0111;
  localparam logic [2:0] OP_IMM_PFX    = 3'b001;

  function automatic logic is_jmp(input logic [5:0] op);
    return op == OP_JMP;
  endfunction

  function automatic logic is_cond_j(input logic [5:0] op);
    return op[5:2] == OP_COND_J_PFX;
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op[5:3] == OP_IMM_PFX;
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Flush empties it in one cycle; push and pop may coincide when full.
module prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rp_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + AW'(1);
      if (do_pop)  rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wp_q] <= wdata;
  end

  // The fetch FSM reserves a slot before requesting, so this never fires.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !(pop && !empty))
  );

endmodule

// File: rtl/instruction_issue_block.sv
// MIPS front end: fetch FSM with one outstanding imem request, prefetch
// FIFO, and a registered issue stage obeying stall and redirect.
module instruction_issue_block #(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(mips_pkg::RESET_PC),
  parameter logic [31:0]       NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid
);

  import mips_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = ADDR_W + 32;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              vld_q, vld_d;

  logic              push, pop;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;
  logic [EW-1:0]     head;

  prefetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata ({fetch_pc_q, imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Fetch FSM: a request is only raised when a FIFO slot is reserved.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    push        = 1'b0;
    pop         = !stall && !redirect && !empty;
    count_after = count + CW'(1) - CW'(pop);
    unique case (state_q)
      IDLE: begin
        if (!redirect && !full) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          if (count_after < CW'(FIFO_DEPTH)) begin
            state_d = REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    ins_d    = ins_q;
    ins_pc_d = ins_pc_q;
    vld_d    = vld_q;
    priority case (1'b1)
      redirect: begin
        ins_d = NOP_WORD;
        vld_d = 1'b0;
      end
      stall: begin
      end
      !empty: begin
        ins_d    = head[31:0];
        ins_pc_d = head[EW-1:32];
        vld_d    = 1'b1;
      end
      default: begin
        ins_d = NOP_WORD;
        vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      ins_q      <= NOP_WORD;
      ins_pc_q   <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      ins_q      <= ins_d;
      ins_pc_q   <= ins_pc_d;
      vld_q      <= vld_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign ins_valid = vld_q;

endmodule

// File: tb/tb_instruction_issue_block.sv
// Bench for instruction_issue_block: vector table for the start-up and
// stall window, scoreboarded memory model for latency/redirect/reset.
module tb_instruction_issue_block;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;

  instruction_issue_block dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          cyc;
  } ent_t;

  vec_t tbl [11];
  ent_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc;
  int lat;
  int wait_cnt;
  bit noack, force_ack, stray_ack;
  bit pending_drop;
  bit found;
  logic        p_stall, p_redir, p_req, p_ack;
  logic [31:0] p_addr;
  logic [31:0] last_ins, last_pc;
  logic        last_v;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cyc          = 0;
    wait_cnt     = 0;
    pending_drop = 1'b0;
    p_stall      = 1'b0;
    p_redir      = 1'b0;
    p_req        = 1'b0;
    p_ack        = 1'b0;
    p_addr       = 32'h0;
    last_ins     = 32'h0;
    last_pc      = 32'h0;
    last_v       = 1'b0;
  endtask

  // Outputs after the last edge, judged against the inputs that caused it.
  task automatic check_outputs();
    ent_t e;
    if (p_redir) begin
      chk1("redir_valid", ins_valid, 1'b0);
      chk("redir_ins", ins, 32'h0);
    end else if (p_stall) begin
      chk("hold_ins", ins, last_ins);
      chk("hold_pc", ins_pc, last_pc);
      chk1("hold_valid", ins_valid, last_v);
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk1("issue_valid", ins_valid, 1'b1);
      chk("issue_pc", ins_pc, e.pc);
      chk("issue_ins", ins, e.ins);
    end else begin
      chk1("bubble_valid", ins_valid, 1'b0);
      chk("bubble_ins", ins, 32'h0);
    end
    if (p_req && !p_ack) begin
      chk1("req_hold", imem_req, 1'b1);
      chk("addr_hold", imem_addr, p_addr);
    end
  endtask

  // One clock: memory response, negedge check, model update, edge, +1.
  task automatic step();
    ent_t e;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (force_ack || (!noack && wait_cnt >= lat)) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr | 32'h1000;
      end
    end else if (stray_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    check_outputs();
    if (redirect) exp_q.delete();
    if (imem_req && imem_ack) begin
      wait_cnt = 0;
      if (redirect || pending_drop) begin
        pending_drop = 1'b0;
      end else begin
        e.pc  = imem_addr;
        e.ins = imem_addr | 32'h1000;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end else if (imem_req) begin
      wait_cnt++;
      if (redirect) pending_drop = 1'b1;
    end
    p_stall  = stall;
    p_redir  = redirect;
    p_req    = imem_req;
    p_ack    = imem_ack;
    p_addr   = imem_addr;
    last_ins = ins;
    last_pc  = ins_pc;
    last_v   = ins_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input string nm);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (ins_valid) found = 1'b1;
    end
    chk1(nm, found, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (!imem_req) found = 1'b1;
    end
    chk1(nm, found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0000};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 32'h1000};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h1004};
    tbl[4]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h04, 32'h1004};
    tbl[5]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h04, 32'h1004};
    tbl[6]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h04, 32'h1004};
    tbl[7]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h08, 32'h1008};
    tbl[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h100C};
    tbl[9]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h0C, 32'h0000};
    tbl[10] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h1010};

    reset       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat         = 0;
    noack       = 1'b0;
    force_ack   = 1'b0;
    stray_ack   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", ins_valid, 1'b0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_pc", ins_pc, 32'h0);
    reset = 1'b1;
    model_reset();

    for (int k = 0; k < 11; k++) begin
      stall = tbl[k].stall;
      step();
      chk1($sformatf("tbl%0d_req", k), imem_req, tbl[k].req);
      chk($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].addr);
      chk1($sformatf("tbl%0d_valid", k), ins_valid, tbl[k].v);
      chk($sformatf("tbl%0d_pc", k), ins_pc, tbl[k].pc);
      chk($sformatf("tbl%0d_ins", k), ins, tbl[k].ins);
    end
    stall = 1'b0;

    lat = 3;
    repeat (30) step();
    lat = 0;

    stall = 1'b1;
    wait_idle("fill_to_idle");
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk1("redir40_bubble", ins_valid, 1'b0);
    wait_valid("redir40_wait");
    chk("redir40_pc", ins_pc, 32'h40);
    chk("redir40_ins", ins, 32'h1040);

    stall = 1'b1;
    wait_idle("drain_prep_idle");
    noack       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    step();
    chk1("req10_req", imem_req, 1'b1);
    chk("req10_addr", imem_addr, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk1("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 32'h10);
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    noack     = 1'b0;
    chk1("drain_done_req", imem_req, 1'b0);
    step();
    chk1("req80_req", imem_req, 1'b1);
    chk("req80_addr", imem_addr, 32'h80);
    wait_valid("req80_wait");
    chk("req80_pc", ins_pc, 32'h80);

    repeat (3) step();
    chk1("pre_rst_req", imem_req, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk1("arst_req", imem_req, 1'b0);
    chk("arst_addr", imem_addr, 32'h0);
    chk1("arst_valid", ins_valid, 1'b0);
    chk("arst_ins", ins, 32'h0);
    chk("arst_pc", ins_pc, 32'h0);
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    wait_valid("post_rst_wait");
    chk("post_rst_pc", ins_pc, 32'h0);
    chk("post_rst_ins", ins, 32'h1000);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
